// File: rtl/hamming_enc_tx.sv
// ============================================================================
// hamming_enc_tx
// Hamming(7,4) encoder with optional single-position error injection and a
// framed serial transmitter (valid/ready in, ser_bit/ser_frame out).
// Revision: 1.0
// ============================================================================
`default_nettype none

module hamming_enc_tx #(
  parameter int BIT_DIV   = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic [2:0] err_pos,
  output logic [6:0] cw_data,
  output logic       ser_bit,
  output logic       ser_frame,
  output logic       ser_start,
  output logic       done,
  output logic       busy
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic [7:0] c_DIV_LAST = 8'(BIT_DIV - 1);
  localparam logic [7:0] c_DIV_PRE  = 8'(BIT_DIV - 2);

  state_t     r_state;
  logic [7:0] r_div_cnt;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic [6:0] r_cw;
  logic       r_frame;
  logic       r_start;
  logic       r_done;

  logic       w_d1, w_d2, w_d3, w_d4;
  logic [6:0] w_enc;
  logic [6:0] w_mask;
  logic [6:0] w_cw;
  logic [6:0] w_ord;
  logic       w_last;
  logic       w_accept;
  logic       w_done_nxt;

  assign w_d1  = in_data[3];
  assign w_d2  = in_data[2];
  assign w_d3  = in_data[1];
  assign w_d4  = in_data[0];
  assign w_enc = {w_d1 ^ w_d2 ^ w_d4, w_d1 ^ w_d3 ^ w_d4, w_d1,
                  w_d2 ^ w_d3 ^ w_d4, w_d2, w_d3, w_d4};

  // Position k (1..7) lives at bit 7-k; err_pos = 0 leaves the mask empty.
  always_comb begin
    w_mask = '0;
    for (int k = 1; k <= 7; k++) begin
      if (err_pos == 3'(k)) w_mask[7-k] = 1'b1;
    end
  end

  assign w_cw = w_enc ^ w_mask;

  // The shift register always emits from bit 6, so LSB-first loads reversed.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign w_ord = w_cw;
  end else begin : g_lsb_first
    assign w_ord = {w_cw[0], w_cw[1], w_cw[2], w_cw[3], w_cw[4], w_cw[5], w_cw[6]};
  end

  assign w_last   = (r_state == S_SHIFT) && (r_bit_cnt == 3'd6) && (r_div_cnt == c_DIV_LAST);
  assign in_ready = (r_state == S_IDLE) || w_last;
  assign w_accept = in_valid && in_ready;

  // done is registered, so flag it one cycle ahead of the final bit clock.
  assign w_done_nxt = (r_state == S_SHIFT) && !w_last &&
                      ((BIT_DIV == 1) ? (r_bit_cnt == 3'd5)
                                      : ((r_bit_cnt == 3'd6) && (r_div_cnt == c_DIV_PRE)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_cw      <= '0;
      r_frame   <= 1'b0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_state   <= S_SHIFT;
        r_cw      <= w_cw;
        r_shift   <= w_ord;
        r_div_cnt <= '0;
        r_bit_cnt <= '0;
        r_frame   <= 1'b1;
        r_start   <= 1'b1;
      end else if (r_state == S_SHIFT) begin
        if (w_last) begin
          r_state   <= S_IDLE;
          r_frame   <= 1'b0;
          r_shift   <= '0;
          r_div_cnt <= '0;
          r_bit_cnt <= '0;
        end else if (r_div_cnt == c_DIV_LAST) begin
          r_div_cnt <= '0;
          r_bit_cnt <= r_bit_cnt + 3'd1;
          r_shift   <= {r_shift[5:0], 1'b0};
        end else begin
          r_div_cnt <= r_div_cnt + 8'd1;
        end
      end
    end
  end

  assign cw_data   = r_cw;
  assign ser_bit   = r_shift[6];
  assign ser_frame = r_frame;
  assign busy      = r_frame;
  assign ser_start = r_start;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_hamming_enc_tx.sv
// ============================================================================
// tb_hamming_enc_tx
// Self-checking bench: three encoder instances (BIT_DIV/MSB_FIRST variants).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hamming_enc_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid  [3];
  logic [3:0] in_data   [3];
  logic [2:0] err_pos   [3];
  logic       in_ready  [3];
  logic [6:0] cw_data   [3];
  logic       ser_bit   [3];
  logic       ser_frame [3];
  logic       ser_start [3];
  logic       done      [3];
  logic       busy      [3];

  int n_chk  = 0;
  int n_pass = 0;

  // Instance 0: BIT_DIV=4 MSB-first; 1: BIT_DIV=1 MSB-first; 2: BIT_DIV=1 LSB-first.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    hamming_enc_tx #(
      .BIT_DIV  ((g == 0) ? 4 : 1),
      .MSB_FIRST((g == 2) ? 0 : 1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .err_pos  (err_pos[g]),
      .cw_data  (cw_data[g]),
      .ser_bit  (ser_bit[g]),
      .ser_frame(ser_frame[g]),
      .ser_start(ser_start[g]),
      .done     (done[g]),
      .busy     (busy[g])
    );
  end

  function automatic int bd_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Reference codeword from positions 1..7 with parity as modulo-2 sums.
  function automatic logic [6:0] ref_cw(input logic [3:0] d, input logic [2:0] e);
    int p[8];
    int d1, d2, d3, d4;
    logic [6:0] r;
    d1 = int'(d[3]); d2 = int'(d[2]); d3 = int'(d[1]); d4 = int'(d[0]);
    p[0] = 0;
    p[1] = (d1 + d2 + d4) % 2;
    p[2] = (d1 + d3 + d4) % 2;
    p[3] = d1;
    p[4] = (d2 + d3 + d4) % 2;
    p[5] = d2;
    p[6] = d3;
    p[7] = d4;
    if (e != 3'd0) p[e] = 1 - p[e];
    r = '0;
    for (int k = 1; k <= 7; k++) r[7-k] = (p[k] != 0);
    return r;
  endfunction

  // Bit b of the frame is position b+1 (MSB-first) or position 7-b (LSB-first).
  function automatic logic exp_bit(input int i, input logic [6:0] cw, input int b);
    int pos;
    pos = (i == 2) ? (7 - b) : (b + 1);
    return cw[7-pos];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Vector: {ser_frame, busy, ser_bit, ser_start, done, in_ready, cw_data[6:0]}
  task automatic check_idle(input int i, input logic [6:0] cw, input string tag);
    logic [12:0] a, x;
    a = {ser_frame[i], busy[i], ser_bit[i], ser_start[i], done[i], in_ready[i], cw_data[i]};
    x = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cw};
    chk($sformatf("idle_%s_u%0d", tag, i), 32'(a), 32'(x));
  endtask

  task automatic send(input int i, input logic [3:0] d, input logic [2:0] e);
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    err_pos[i]  = e;
    chk($sformatf("ready_before_accept_u%0d", i), 32'(in_ready[i]), 32'd1);
    @(negedge clk);
  endtask

  // Entered at the negedge of the first frame cycle; leaves at the negedge
  // after the final cycle. nv/nd/ne are presented during the final cycle.
  task automatic check_frame(input int i, input logic [6:0] cw, input bit noise,
                             input bit nv, input logic [3:0] nd, input logic [2:0] ne);
    int bd, n;
    logic last;
    logic [12:0] a, x;
    bd = bd_of(i);
    n  = 7 * bd;
    in_valid[i] = 1'b0;
    for (int k = 0; k < n; k++) begin
      last = (k == n - 1);
      a = {ser_frame[i], busy[i], ser_bit[i], ser_start[i], done[i], in_ready[i], cw_data[i]};
      x = {1'b1, 1'b1, exp_bit(i, cw, k / bd), (k == 0), last, last, cw};
      chk($sformatf("frame_u%0d_cw%07b_k%0d", i, cw, k), 32'(a), 32'(x));
      if (last) begin
        in_valid[i] = nv;
        in_data[i]  = nd;
        err_pos[i]  = ne;
      end else if (noise) begin
        in_valid[i] = 1'($urandom_range(0, 1));
        in_data[i]  = 4'($urandom);
        err_pos[i]  = 3'($urandom);
      end
      @(negedge clk);
    end
  endtask

  task automatic run(input int i, input logic [3:0] d, input logic [2:0] e, input logic [6:0] cw);
    send(i, d, e);
    check_frame(i, cw, 1'b0, 1'b0, 4'd0, 3'd0);
    check_idle(i, cw, "post");
  endtask

  typedef struct {
    logic [3:0] d;
    logic [2:0] e;
    logic [6:0] cw;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int seen;
    logic [6:0] lastcw;

    tbl[0] = '{4'b0000, 3'd0, 7'b0000000};
    tbl[1] = '{4'b1000, 3'd0, 7'b1110000};
    tbl[2] = '{4'b1011, 3'd0, 7'b0110011};
    tbl[3] = '{4'b1111, 3'd0, 7'b1111111};
    tbl[4] = '{4'b1111, 3'd3, 7'b1101111};
    tbl[5] = '{4'b0001, 3'd0, 7'b1101001};
    tbl[6] = '{4'b0100, 3'd0, 7'b1001100};
    tbl[7] = '{4'b0010, 3'd0, 7'b0101010};
    tbl[8] = '{4'b1000, 3'd7, 7'b1110001};
    tbl[9] = '{4'b0000, 3'd1, 7'b1000000};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = '0;
      err_pos[i]  = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle(i, 7'd0, "reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors on the BIT_DIV=4 MSB-first instance.
    for (int t = 0; t < 10; t++) run(0, tbl[t].d, tbl[t].e, tbl[t].cw);

    // All 16 nibbles without corruption against the reference model.
    for (int d = 0; d < 16; d++) run(1, 4'(d), 3'd0, ref_cw(4'(d), 3'd0));

    // Back-to-back zero-gap frames, BIT_DIV=1.
    send(1, 4'b1000, 3'd0);
    check_frame(1, 7'b1110000, 1'b0, 1'b1, 4'b1011, 3'd0);
    check_frame(1, 7'b0110011, 1'b0, 1'b0, 4'd0, 3'd0);
    check_idle(1, 7'b0110011, "b2b");

    // LSB-first ordering: 1011 -> 1,1,0,0,1,1,0.
    run(2, 4'b1011, 3'd0, 7'b0110011);

    // Reset asserted at the start of bit 3 of a BIT_DIV=4 frame.
    send(0, 4'b1111, 3'd0);
    in_valid[0] = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_reset_frame", 32'(ser_frame[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_idle(0, 7'd0, "async_reset");
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done[0] || ser_frame[0]) seen++;
    end
    chk("no_done_after_abort", 32'(seen), 32'd0);
    check_idle(0, 7'd0, "after_abort");
    run(0, 4'b1011, 3'd0, 7'b0110011);

    // Randomized frames with mid-frame in_valid noise and random back-to-back chains.
    for (int r = 0; r < 40; r++) begin
      int i, chain;
      logic [3:0] cd, nd;
      logic [2:0] ce, ne;
      bit nv;
      i  = $urandom_range(0, 2);
      cd = 4'($urandom);
      ce = 3'($urandom);
      chain = 0;
      send(i, cd, ce);
      do begin
        nv = (chain < 3) && ($urandom_range(0, 1) == 1);
        nd = 4'($urandom);
        ne = 3'($urandom);
        lastcw = ref_cw(cd, ce);
        check_frame(i, lastcw, 1'b1, nv, nd, ne);
        cd = nd;
        ce = ne;
        chain++;
      end while (nv);
      in_valid[i] = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_idle(i, lastcw, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
